// File: rtl/switch_conditioner_if.sv
// Board-side switch/button signals and their conditioned, CPU-facing
// counterparts, bundled so the conditioner and its consumers share one bundle.
//
// Signalling: there is no valid/ready handshake on this bundle. switchUpdate
// and stepPulse are single-cycle strobes that need no acknowledge.
// switchUpdate is high for exactly the one cycle in which cpuSwitches holds a
// newly accepted word. stepPulse is high for exactly one cycle per accepted
// button press.
`timescale 1ns/1ps
interface switch_conditioner_if;
   logic [7:0] switchesRaw;
   logic       stepRaw;
   logic [7:0] cpuSwitches;
   logic       switchUpdate;
   logic       stepPulse;

   // Board / CPU side: drives the raw inputs and consumes the conditioned outputs.
   modport master (
      output switchesRaw,
      output stepRaw,
      input  cpuSwitches,
      input  switchUpdate,
      input  stepPulse
   );

   // Conditioner side: consumes the raw inputs and produces the conditioned outputs.
   modport slave (
      input  switchesRaw,
      input  stepRaw,
      output cpuSwitches,
      output switchUpdate,
      output stepPulse
   );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronizes and debounces the 8 board slide switches and the step
// push-button. The switch word is accepted as a whole once it has been stable
// for DEBOUNCE_CYCLES synchronized cycles. The button produces one pulse per
// accepted press. Every output is registered.
`timescale 1ns/1ps
module switch_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 boardCLK,
   input  logic                 reset,
   switch_conditioner_if.slave  bus
);

   localparam int               CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronizer stages
   logic [7:0] sw_s1;
   logic [7:0] sw_s2;
   logic       st_s1;
   logic       st_s2;

   // Switch path state
   logic [7:0]       sw_cand;
   logic [CNT_W-1:0] sw_cnt;
   logic [7:0]       sw_out;
   logic             sw_upd;

   // Button path state
   logic             st_cand;
   logic [CNT_W-1:0] st_cnt;
   logic             st_level;
   logic             st_pulse;

   // Acceptance conditions: the candidate has been held long enough and still matches
   logic sw_accept;
   logic st_accept;

   assign sw_accept = (sw_cnt == CNT_MAX) && (sw_s2 == sw_cand) && (sw_cand != sw_out);
   assign st_accept = (st_cnt == CNT_MAX) && (st_s2 == st_cand) && (st_cand != st_level);

   // Two-flop synchronizers bring the asynchronous board inputs into boardCLK
   always_ff @(posedge boardCLK or negedge reset) begin
      if (!reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
         st_s1 <= 1'b0;
         st_s2 <= 1'b0;
      end else begin
         sw_s1 <= bus.switchesRaw;
         sw_s2 <= sw_s1;
         st_s1 <= bus.stepRaw;
         st_s2 <= st_s1;
      end
   end

   // Switch candidate tracking: any bit change reloads the whole word and restarts the count
   always_ff @(posedge boardCLK or negedge reset) begin
      if (!reset) begin
         sw_cand <= '0;
         sw_cnt  <= '0;
      end else if (sw_s2 != sw_cand) begin
         sw_cand <= sw_s2;
         sw_cnt  <= '0;
      end else if (sw_cnt < CNT_MAX) begin
         sw_cnt  <= sw_cnt + 1'b1;
      end
   end

   // Switch output register: the stable word is accepted once, with a one-cycle strobe
   always_ff @(posedge boardCLK or negedge reset) begin
      if (!reset) begin
         sw_out <= '0;
         sw_upd <= 1'b0;
      end else begin
         sw_upd <= 1'b0;
         if (sw_accept) begin
            sw_out <= sw_cand;
            sw_upd <= 1'b1;
         end
      end
   end

   // Button candidate tracking: independent counter, same scheme as the switch word
   always_ff @(posedge boardCLK or negedge reset) begin
      if (!reset) begin
         st_cand <= 1'b0;
         st_cnt  <= '0;
      end else if (st_s2 != st_cand) begin
         st_cand <= st_s2;
         st_cnt  <= '0;
      end else if (st_cnt < CNT_MAX) begin
         st_cnt  <= st_cnt + 1'b1;
      end
   end

   // Debounced button level; pulse only on the accepted rising transition
   always_ff @(posedge boardCLK or negedge reset) begin
      if (!reset) begin
         st_level <= 1'b0;
         st_pulse <= 1'b0;
      end else begin
         st_pulse <= 1'b0;
         if (st_accept) begin
            st_level <= st_cand;
            st_pulse <= st_cand;
         end
      end
   end

   assign bus.cpuSwitches  = sw_out;
   assign bus.switchUpdate = sw_upd;
   assign bus.stepPulse    = st_pulse;

   // Strobes never last longer than one cycle: once a value is accepted, the candidate equals the output
   a_upd_one_cycle : assert property (@(posedge boardCLK) disable iff (!reset) sw_upd |=> !sw_upd);
   a_pulse_one_cycle : assert property (@(posedge boardCLK) disable iff (!reset) st_pulse |=> !st_pulse);

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner. A reference model predicts every
// output from one rule. A value is accepted once the last DEBOUNCE_CYCLES+1
// synchronized samples agree and differ from the current output. The model
// tracks a sample history and does not model the RTL counters. A negedge
// compare process checks the DUT against the model on every cycle. Directed
// literal checks pin latencies and strobe counts.
`timescale 1ns/1ps
module tb_switch_conditioner;
   localparam int D = 16;

   // Clock and reset
   logic boardCLK = 1'b0;
   logic reset;
   always #5 boardCLK = ~boardCLK;

   switch_conditioner_if bus();

   switch_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .boardCLK (boardCLK),
      .reset    (reset),
      .bus      (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   int upd_seen = 0;
   int pulse_seen = 0;

   // Reference model: sample history, one entry per rising edge
   logic [7:0] sw_hist[$];
   logic       st_hist[$];
   logic [7:0] m_cpu   = 8'h00;
   logic       m_upd   = 1'b0;
   logic       m_level = 1'b0;
   logic       m_pulse = 1'b0;

   task automatic model_clear();
      sw_hist.delete();
      st_hist.delete();
      for (int i = 0; i < D + 2; i++) begin
         sw_hist.push_back(8'h00);
         st_hist.push_back(1'b0);
      end
      m_cpu   = 8'h00;
      m_upd   = 1'b0;
      m_level = 1'b0;
      m_pulse = 1'b0;
   endtask

   // The sample taken at edge n reaches the debouncer two edges later.
   // Edge n therefore decides using samples n-D-2 .. n-2.
   always @(posedge boardCLK or negedge reset) begin
      logic [7:0] sv;
      logic       tv;
      bit         sw_ok;
      bit         st_ok;
      int         last;
      if (!reset) begin
         model_clear();
      end else begin
         last  = sw_hist.size() - 2;
         sv    = sw_hist[last];
         tv    = st_hist[last];
         sw_ok = 1'b1;
         st_ok = 1'b1;
         for (int k = last - D; k <= last; k++) begin
            if (sw_hist[k] != sv) sw_ok = 1'b0;
            if (st_hist[k] != tv) st_ok = 1'b0;
         end
         m_upd = sw_ok && (sv != m_cpu);
         if (m_upd) m_cpu = sv;
         m_pulse = st_ok && (tv != m_level) && tv;
         if (st_ok) m_level = tv;
         sw_hist.push_back(bus.switchesRaw);
         void'(sw_hist.pop_front());
         st_hist.push_back(bus.stepRaw);
         void'(st_hist.pop_front());
      end
   end

   // Compare process: DUT against model on every falling edge
   always @(negedge boardCLK) begin
      checks++;
      if (bus.cpuSwitches !== m_cpu || bus.switchUpdate !== m_upd || bus.stepPulse !== m_pulse) begin
         errors++;
         $display("FAIL model_compare t=%0t: got cpu=%h upd=%b pulse=%b, expected cpu=%h upd=%b pulse=%b",
                  $time, bus.cpuSwitches, bus.switchUpdate, bus.stepPulse, m_cpu, m_upd, m_pulse);
      end
      if (bus.switchUpdate === 1'b1) upd_seen++;
      if (bus.stepPulse === 1'b1) pulse_seen++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Counts rising edges until cpuSwitches shows v. Reports -1 if the bound expires.
   task automatic wait_accept(input logic [7:0] v, input int exp_edges, input string name);
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 60) begin
         @(posedge boardCLK);
         #1;
         n++;
         if (bus.cpuSwitches === v) seen = 1'b1;
      end
      check(name, seen ? n : -1, exp_edges);
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      bit both_ok;
      model_clear();
      bus.switchesRaw = 8'h71;
      bus.stepRaw     = 1'b0;
      reset           = 1'b0;

      // Reset state
      #7;
      check("reset_cpu", int'(bus.cpuSwitches), 0);
      check("reset_upd", int'(bus.switchUpdate), 0);
      check("reset_pulse", int'(bus.stepPulse), 0);

      // Setup: word held through reset release is accepted 19 edges later
      #13;
      reset = 1'b1;
      wait_accept(8'h71, 19, "setup_latency");
      repeat (10) @(negedge boardCLK);
      check("setup_upd_count", upd_seen, 1);
      check("setup_model_cpu", int'(m_cpu), 'h71);

      // Glitch: 10 cycles of 00, then back to 71
      upd_seen = 0;
      @(negedge boardCLK);
      bus.switchesRaw = 8'h00;
      repeat (10) @(negedge boardCLK);
      bus.switchesRaw = 8'h71;
      repeat (40) @(negedge boardCLK);
      check("glitch_cpu", int'(bus.cpuSwitches), 'h71);
      check("glitch_upd_count", upd_seen, 0);

      // Change: 71 -> A5, accepted after edge 18 (19th counted edge)
      upd_seen = 0;
      @(negedge boardCLK);
      bus.switchesRaw = 8'hA5;
      wait_accept(8'hA5, 19, "change_latency");
      repeat (5) @(negedge boardCLK);
      check("change_upd_count", upd_seen, 1);
      check("change_model_cpu", int'(m_cpu), 'hA5);

      // Button: 5 bounces 3 cycles apart, hold 100 cycles, then release
      upd_seen   = 0;
      pulse_seen = 0;
      for (int i = 0; i < 5; i++) begin
         bus.stepRaw = ~bus.stepRaw;
         repeat (3) @(negedge boardCLK);
      end
      repeat (100) @(negedge boardCLK);
      check("button_press_pulses", pulse_seen, 1);
      bus.stepRaw = 1'b0;
      repeat (40) @(negedge boardCLK);
      check("button_release_pulses", pulse_seen, 1);
      check("button_no_switch_upd", upd_seen, 0);

      // Simultaneous acceptance on both paths
      upd_seen   = 0;
      pulse_seen = 0;
      @(negedge boardCLK);
      bus.switchesRaw = 8'h0F;
      bus.stepRaw     = 1'b1;
      both_ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge boardCLK);
         if (bus.switchUpdate === 1'b1 || bus.stepPulse === 1'b1) begin
            both_ok = (bus.switchUpdate === 1'b1) && (bus.stepPulse === 1'b1);
            break;
         end
      end
      check("simultaneous_strobes", int'(both_ok), 1);
      check("simultaneous_cpu", int'(bus.cpuSwitches), 'h0F);
      repeat (5) @(negedge boardCLK);
      bus.stepRaw = 1'b0;
      repeat (30) @(negedge boardCLK);

      // Reset mid-count: 3C with button pressed, reset while the counter is at 10
      @(negedge boardCLK);
      bus.switchesRaw = 8'h3C;
      bus.stepRaw     = 1'b1;
      upd_seen   = 0;
      pulse_seen = 0;
      repeat (13) @(posedge boardCLK);
      #2;
      reset = 1'b0;
      #1;
      check("midreset_cpu", int'(bus.cpuSwitches), 0);
      check("midreset_upd", int'(bus.switchUpdate), 0);
      check("midreset_pulse", int'(bus.stepPulse), 0);
      @(negedge boardCLK);
      reset = 1'b1;
      wait_accept(8'h3C, 19, "midreset_latency");
      repeat (5) @(negedge boardCLK);
      check("midreset_upd_count", upd_seen, 1);
      check("midreset_pulse_count", pulse_seen, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
